// File: rtl/tap_ctrl_if.sv
// tap_ctrl_if: bundles the TAP controller's per-cycle signals.
//   master modport: TAP controller side (samples tms/tdo sources, drives state and strobes)
//   slave modport : JTAG core / pad side (drives tms and register serial outputs)
// Signals:
//   tms, instr_tdo, dr_tdo        : inputs to the controller
//   state[3:0]                    : registered TAP state code
//   test_logic_reset, run_test_idle, capture_ir, shift_ir, update_ir,
//   capture_dr, shift_dr, update_dr, select_ir : state decodes
//   tdo, tdo_en                   : serial output and pad enable
interface tap_ctrl_if;
   logic       tms;
   logic       instr_tdo;
   logic       dr_tdo;
   logic [3:0] state;
   logic       test_logic_reset;
   logic       run_test_idle;
   logic       capture_ir;
   logic       shift_ir;
   logic       update_ir;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       select_ir;
   logic       tdo;
   logic       tdo_en;

   modport master (
      input  tms, instr_tdo, dr_tdo,
      output state, test_logic_reset, run_test_idle, capture_ir, shift_ir, update_ir,
             capture_dr, shift_dr, update_dr, select_ir, tdo, tdo_en
   );

   modport slave (
      output tms, instr_tdo, dr_tdo,
      input  state, test_logic_reset, run_test_idle, capture_ir, shift_ir, update_ir,
             capture_dr, shift_dr, update_dr, select_ir, tdo, tdo_en
   );
endinterface

// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP state machine with strobe decode and TDO select.
// Ports:
//   TCK    : test clock, all state changes on its rising edge
//   TRST   : synchronous active-high reset to Test-Logic-Reset (beats TMS)
//   tap_io : tap_ctrl_if.master bundle (tms, register serial outputs in;
//            state code, capture/shift/update strobes, select_ir, tdo, tdo_en out)
module tap_ctrl (
   input logic        TCK,
   input logic        TRST,
   tap_ctrl_if.master tap_io
);

   // Encoding is fixed; all 16 codes are real states so no recovery path exists.
   typedef enum logic [3:0] {
      StEx2Dr = 4'h0,
      StEx1Dr = 4'h1,
      StShDr  = 4'h2,
      StPauDr = 4'h3,
      StSelIr = 4'h4,
      StUpdDr = 4'h5,
      StCapDr = 4'h6,
      StSelDr = 4'h7,
      StEx2Ir = 4'h8,
      StEx1Ir = 4'h9,
      StShIr  = 4'hA,
      StPauIr = 4'hB,
      StRti   = 4'hC,
      StUpdIr = 4'hD,
      StCapIr = 4'hE,
      StTlr   = 4'hF
   } state_e;

   state_e state_q, state_d;

   logic tlr, rti, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, sel_ir;

   always_ff @(posedge TCK) begin
      if (TRST) begin
         state_q <= StTlr;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tlr     = 1'b0;
      rti     = 1'b0;
      cap_ir  = 1'b0;
      sh_ir   = 1'b0;
      upd_ir  = 1'b0;
      cap_dr  = 1'b0;
      sh_dr   = 1'b0;
      upd_dr  = 1'b0;
      sel_ir  = 1'b0;
      unique case (state_q)
         StTlr: begin
            state_d = tap_io.tms ? StTlr : StRti;
            tlr     = 1'b1;
         end
         StRti: begin
            state_d = tap_io.tms ? StSelDr : StRti;
            rti     = 1'b1;
         end
         StSelDr: state_d = tap_io.tms ? StSelIr : StCapDr;
         StCapDr: begin
            state_d = tap_io.tms ? StEx1Dr : StShDr;
            cap_dr  = 1'b1;
         end
         StShDr: begin
            state_d = tap_io.tms ? StEx1Dr : StShDr;
            sh_dr   = 1'b1;
         end
         StEx1Dr: state_d = tap_io.tms ? StUpdDr : StPauDr;
         StPauDr: state_d = tap_io.tms ? StEx2Dr : StPauDr;
         StEx2Dr: state_d = tap_io.tms ? StUpdDr : StShDr;
         StUpdDr: begin
            state_d = tap_io.tms ? StSelDr : StRti;
            upd_dr  = 1'b1;
         end
         StSelIr: begin
            state_d = tap_io.tms ? StTlr : StCapIr;
            sel_ir  = 1'b1;
         end
         StCapIr: begin
            state_d = tap_io.tms ? StEx1Ir : StShIr;
            cap_ir  = 1'b1;
            sel_ir  = 1'b1;
         end
         StShIr: begin
            state_d = tap_io.tms ? StEx1Ir : StShIr;
            sh_ir   = 1'b1;
            sel_ir  = 1'b1;
         end
         StEx1Ir: begin
            state_d = tap_io.tms ? StUpdIr : StPauIr;
            sel_ir  = 1'b1;
         end
         StPauIr: begin
            state_d = tap_io.tms ? StEx2Ir : StPauIr;
            sel_ir  = 1'b1;
         end
         StEx2Ir: begin
            state_d = tap_io.tms ? StUpdIr : StShIr;
            sel_ir  = 1'b1;
         end
         StUpdIr: begin
            state_d = tap_io.tms ? StSelDr : StRti;
            upd_ir  = 1'b1;
            sel_ir  = 1'b1;
         end
         default: state_d = StTlr;
      endcase
   end

   assign tap_io.state            = state_q;
   assign tap_io.test_logic_reset = tlr;
   assign tap_io.run_test_idle    = rti;
   assign tap_io.capture_ir       = cap_ir;
   assign tap_io.shift_ir         = sh_ir;
   assign tap_io.update_ir        = upd_ir;
   assign tap_io.capture_dr       = cap_dr;
   assign tap_io.shift_dr         = sh_dr;
   assign tap_io.update_dr        = upd_dr;
   assign tap_io.select_ir        = sel_ir;
   // Outside a shift TDO still follows DR_TDO; the pad is tri-stated via tdo_en.
   assign tap_io.tdo              = sh_ir ? tap_io.instr_tdo : tap_io.dr_tdo;
   assign tap_io.tdo_en           = sh_ir | sh_dr;

endmodule

// File: tb/tb_tap_ctrl.sv
// tb_tap_ctrl: self-checking bench for tap_ctrl (role/column model plus directed vectors).
module tb_tap_ctrl;

   logic tck = 1'b0;
   logic trst;
   always #5 tck = ~tck;

   tap_ctrl_if tap_if ();

   tap_ctrl dut (
      .TCK    (tck),
      .TRST   (trst),
      .tap_io (tap_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model: state as (role, column) ----------------
   localparam int RTlr = 0, RRti = 1, RSel = 2, RCap = 3, RSh = 4;
   localparam int REx1 = 5, RPau = 6, REx2 = 7, RUpd = 8;

   int m_role = RTlr;
   bit m_ir = 1'b0;
   bit m_valid = 1'b0;

   function automatic int next_role(input int role, input bit ir, input bit tms);
      case (role)
         RTlr:    return tms ? RTlr : RRti;
         RRti:    return tms ? RSel : RRti;
         RSel:    return tms ? (ir ? RTlr : RSel) : RCap;
         RCap:    return tms ? REx1 : RSh;
         RSh:     return tms ? REx1 : RSh;
         REx1:    return tms ? RUpd : RPau;
         RPau:    return tms ? REx2 : RPau;
         REx2:    return tms ? RUpd : RSh;
         default: return tms ? RSel : RRti;
      endcase
   endfunction

   function automatic bit next_ir(input int role, input bit ir, input bit tms);
      if (role == RTlr || role == RRti || role == RUpd) return 1'b0;
      if (role == RSel && tms) return !ir;
      return ir;
   endfunction

   function automatic logic [3:0] code_of(input int role, input bit ir);
      logic [3:0] dr_c [9];
      logic [3:0] ir_c [9];
      dr_c = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5};
      ir_c = '{4'hF, 4'hC, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
      return ir ? ir_c[role] : dr_c[role];
   endfunction

   // {tlr, rti, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, sel_ir, tdo_en, tdo}
   function automatic logic [10:0] exp_out(input int role, input bit ir, input logic itdo,
                                           input logic dtdo);
      logic [10:0] o;
      o = '0;
      o[10] = (role == RTlr);
      o[9]  = (role == RRti);
      o[8]  = ir && role == RCap;
      o[7]  = ir && role == RSh;
      o[6]  = ir && role == RUpd;
      o[5]  = !ir && role == RCap;
      o[4]  = !ir && role == RSh;
      o[3]  = !ir && role == RUpd;
      o[2]  = ir && role >= RSel;
      o[1]  = (role == RSh);
      o[0]  = (ir && role == RSh) ? itdo : dtdo;
      return o;
   endfunction

   always @(posedge tck) begin
      if (trst) begin
         m_role  <= RTlr;
         m_ir    <= 1'b0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_role <= next_role(m_role, m_ir, tap_if.tms);
         m_ir   <= next_ir(m_role, m_ir, tap_if.tms);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge tck) begin
      if (m_valid) begin
         check("cycle_state", 64'(tap_if.state), 64'(code_of(m_role, m_ir)));
         check("cycle_outputs",
               64'({tap_if.test_logic_reset, tap_if.run_test_idle, tap_if.capture_ir,
                    tap_if.shift_ir, tap_if.update_ir, tap_if.capture_dr, tap_if.shift_dr,
                    tap_if.update_dr, tap_if.select_ir, tap_if.tdo_en, tap_if.tdo}),
               64'(exp_out(m_role, m_ir, tap_if.instr_tdo, tap_if.dr_tdo)));
      end
   end

   // ---------------- directed stimulus ----------------
   int n_cap_ir, n_sh_ir, n_upd_ir, n_sh_dr, n_upd_dr, n_sel_ir, n_rti, n_tdo_en, n_tdo_bad;
   logic [3:0] st_q [$];

   task automatic clr();
      n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0; n_sh_dr = 0; n_upd_dr = 0;
      n_sel_ir = 0; n_rti = 0; n_tdo_en = 0; n_tdo_bad = 0;
      st_q.delete();
   endtask

   task automatic step(input bit t, input bit r = 1'b0);
      tap_if.tms       = t;
      trst             = r;
      tap_if.instr_tdo = 1'($urandom);
      tap_if.dr_tdo    = 1'($urandom);
      @(posedge tck);
      #1;
      n_cap_ir += int'(tap_if.capture_ir);
      n_sh_ir  += int'(tap_if.shift_ir);
      n_upd_ir += int'(tap_if.update_ir);
      n_sh_dr  += int'(tap_if.shift_dr);
      n_upd_dr += int'(tap_if.update_dr);
      n_sel_ir += int'(tap_if.select_ir);
      n_rti    += int'(tap_if.run_test_idle);
      n_tdo_en += int'(tap_if.tdo_en);
      if (tap_if.shift_ir && tap_if.tdo !== tap_if.instr_tdo) n_tdo_bad++;
      st_q.push_back(tap_if.state);
   endtask

   task automatic run(input string s);
      for (int i = 0; i < s.len(); i++) step(s[i] == 8'h31);
   endtask

   function automatic logic [63:0] pack_states();
      logic [63:0] v;
      v = '0;
      foreach (st_q[i]) v = {v[59:0], st_q[i]};
      return v;
   endfunction

   string      path [16];
   logic [3:0] n0 [16];
   logic [3:0] n1 [16];

   task automatic goto(input int s);
      step(1'b0, 1'b1);
      run(path[s]);
   endtask

   initial begin
      path = '{"010101", "0101", "0100", "01010", "011", "01011", "010", "01",
               "0110101", "01101", "01100", "011010", "0", "011011", "0110", ""};
      n0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
      n1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
      tap_if.tms       = 1'b0;
      tap_if.instr_tdo = 1'b0;
      tap_if.dr_tdo    = 1'b0;
      trst             = 1'b1;
      clr();

      // Reset, then reset again from Shift-DR.
      step(1'b0, 1'b1);
      check("reset_state", 64'(tap_if.state), 64'hF);
      goto(2);
      check("reach_shdr", 64'(tap_if.state), 64'h2);
      step(1'b1, 1'b1);
      check("trst_from_shdr_state", 64'(tap_if.state), 64'hF);
      check("trst_from_shdr_strobes",
            64'({tap_if.test_logic_reset, tap_if.run_test_idle, tap_if.capture_ir,
                 tap_if.shift_ir, tap_if.update_ir, tap_if.capture_dr, tap_if.shift_dr,
                 tap_if.update_dr, tap_if.select_ir, tap_if.tdo_en}),
            64'b10_0000_0000);
      check("trst_tdo_follows_dr", 64'(tap_if.tdo), 64'(tap_if.dr_tdo));

      // Five ones from every state.
      for (int s = 0; s < 16; s++) begin
         goto(s);
         check($sformatf("reach_%0h", s), 64'(tap_if.state), 64'(s));
         run("11111");
         check($sformatf("five_ones_from_%0h", s), 64'(tap_if.state), 64'hF);
      end

      // Every single-step transition.
      for (int s = 0; s < 16; s++) begin
         for (int t = 0; t < 2; t++) begin
            goto(s);
            step(t[0]);
            check($sformatf("step_%0h_tms%0d", s, t), 64'(tap_if.state),
                  64'(t != 0 ? n1[s] : n0[s]));
         end
      end

      // IR scan from RTI.
      goto(12);
      clr();
      run("1100000110");
      check("ir_scan_path", pack_states(), 64'h74EAAAA9DC);
      check("ir_capture_cnt", 64'(n_cap_ir), 64'd1);
      check("ir_shift_cnt", 64'(n_sh_ir), 64'd4);
      check("ir_tdo_en_cnt", 64'(n_tdo_en), 64'd4);
      check("ir_update_cnt", 64'(n_upd_ir), 64'd1);
      check("ir_tdo_mux", 64'(n_tdo_bad), 64'd0);

      // DR scan with pause from RTI.
      goto(12);
      clr();
      run("100010010110");
      check("dr_scan_path", pack_states(), 64'h76221330215C);
      check("dr_shift_cnt", 64'(n_sh_dr), 64'd3);
      check("dr_update_cnt", 64'(n_upd_dr), 64'd1);
      check("dr_select_ir_cnt", 64'(n_sel_ir), 64'd0);

      // Reset mid IR shift: no Update-IR afterwards.
      goto(10);
      check("reach_shir", 64'(tap_if.state), 64'hA);
      clr();
      step(1'b0, 1'b1);
      check("midshift_trst_state", 64'(tap_if.state), 64'hF);
      check("midshift_shift_drop", 64'(tap_if.shift_ir), 64'd0);
      run("000");
      check("midshift_no_update", 64'(n_upd_ir), 64'd0);

      // Idle hold.
      step(1'b0, 1'b1);
      clr();
      run("00000000000000000000");
      check("idle_first", 64'(st_q[0]), 64'hC);
      check("idle_rti_cnt", 64'(n_rti), 64'd20);
      check("idle_final_state", 64'(tap_if.state), 64'hC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
